// File: rtl/dct2_2d_stream.sv
// Streaming NxN 2D DCT-II wrapper around an external combinational 1D core.
// Define DCT2_2D_SAT_EN to saturate pass-1 results instead of wrapping them.
module dct2_2d_stream #(
   parameter int N  = 8,
   parameter int W  = 8,
   parameter int CW = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N*W-1:0]  in_data,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [N*CW-1:0] out_data,
   output logic            out_last,
   output logic            busy,
   output logic [N*W-1:0]  core_in,
   input  logic [N*CW-1:0] core_out
);

   localparam int RW = $clog2(N);
   localparam logic [RW-1:0] LAST = RW'(N - 1);
   localparam logic [RW-1:0] PREV = RW'(N - 2);

   typedef enum logic {LOAD, DRAIN} state_t;

   state_t        state;
   logic [RW-1:0] rc;
   logic [W-1:0]  mem [N][N];
   logic [N*W-1:0] row_q;

`ifdef DCT2_2D_SAT_EN
   localparam logic signed [CW-1:0] MAXV =
      {{(CW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [CW-1:0] MINV =
      {{(CW-W+1){1'b1}}, {(W-1){1'b0}}};

   function automatic logic [W-1:0] narrow(
      input logic signed [CW-1:0] v
   );
      if (v > MAXV)
         narrow = MAXV[W-1:0];
      else if (v < MINV)
         narrow = MINV[W-1:0];
      else
         narrow = v[W-1:0];
   endfunction
`else
   function automatic logic [W-1:0] narrow(
      input logic [CW-1:0] v
   );
      narrow = v[W-1:0];
   endfunction
`endif

   always_comb begin
      row_q = '0;
      for (int j = 0; j < N; j++)
         row_q[(N-1-j)*W +: W] = mem[rc][j];
   end

   assign core_in  = (state == DRAIN) ? row_q : in_data;
   assign out_data = core_out;
   assign busy     = (state == DRAIN) || (rc != '0);

   // Pass-1 rows are stored transposed so pass 2 reads columns as rows.
   always_ff @(posedge clk) begin
      if (state == LOAD && in_valid) begin
         for (int c = 0; c < N; c++)
            mem[c][rc] <= narrow(core_out[(N-1-c)*CW +: CW]);
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= LOAD;
         rc        <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
      end else begin
         unique case (state)
            LOAD: begin
               if (in_valid) begin
                  if (rc == LAST) begin
                     rc        <= '0;
                     state     <= DRAIN;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     out_last  <= 1'b0;
                  end else begin
                     rc <= rc + RW'(1);
                  end
               end
            end
            DRAIN: begin
               if (out_ready) begin
                  if (rc == LAST) begin
                     rc        <= '0;
                     state     <= LOAD;
                     in_ready  <= 1'b1;
                     out_valid <= 1'b0;
                     out_last  <= 1'b0;
                  end else begin
                     rc       <= rc + RW'(1);
                     out_last <= (rc == PREV);
                  end
               end
            end
            default: state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_dct2_2d_stream.sv
// Directed self-checking bench for dct2_2d_stream (N=8 and N=4 instances).
module tb_dct2_2d_stream;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int gain = 1;

   logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
   logic         out_last, busy;
   logic [63:0]  in_data = '0, core_in;
   logic [127:0] out_data, core_out;

   logic         in4_valid = 1'b0, in4_ready, out4_valid, out4_ready = 1'b0;
   logic         out4_last, busy4;
   logic [31:0]  in4_data = '0, core4_in;
   logic [63:0]  out4_data, core4_out;

   function automatic logic [127:0] core8(input logic [63:0] x, input int g);
      logic signed [7:0] e;
      core8 = '0;
      for (int j = 0; j < 8; j++) begin
         e = x[(7-j)*8 +: 8];
         core8[(7-j)*16 +: 16] = 16'(int'(e) * g);
      end
   endfunction

   function automatic logic [63:0] core4(input logic [31:0] x);
      logic signed [7:0] e;
      core4 = '0;
      for (int j = 0; j < 4; j++) begin
         e = x[(3-j)*8 +: 8];
         core4[(3-j)*16 +: 16] = 16'(int'(e));
      end
   endfunction

   always_comb core_out = core8(core_in, gain);
   always_comb core4_out = core4(core4_in);

   dct2_2d_stream #(.N(8), .W(8), .CW(16)) u8 (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .busy(busy),
      .core_in(core_in), .core_out(core_out)
   );

   dct2_2d_stream #(.N(4), .W(8), .CW(16)) u4 (
      .clk(clk), .reset(reset),
      .in_valid(in4_valid), .in_ready(in4_ready), .in_data(in4_data),
      .out_valid(out4_valid), .out_ready(out4_ready), .out_data(out4_data),
      .out_last(out4_last), .busy(busy4),
      .core_in(core4_in), .core_out(core4_out)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs,
                      input logic [127:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] row_x(input int r, input int off,
                                         input bit flat);
      row_x = '0;
      for (int j = 0; j < 8; j++)
         row_x[(7-j)*8 +: 8] = flat ? 8'd100 : 8'(8*r + j + off);
   endfunction

   function automatic logic [127:0] row_y(input int k, input int off,
                                          input bit flat);
      row_y = '0;
      for (int j = 0; j < 8; j++) begin
         if (flat)
`ifdef DCT2_2D_SAT_EN
            row_y[(7-j)*16 +: 16] = 16'(508);
`else
            row_y[(7-j)*16 +: 16] = 16'(-448);
`endif
         else
            row_y[(7-j)*16 +: 16] = 16'(8*j + k + off);
      end
   endfunction

   function automatic logic [31:0] row4_x(input int r, input int off);
      row4_x = '0;
      for (int j = 0; j < 4; j++)
         row4_x[(3-j)*8 +: 8] = 8'(4*r + j + off);
   endfunction

   function automatic logic [63:0] row4_y(input int k, input int off);
      row4_y = '0;
      for (int j = 0; j < 4; j++)
         row4_y[(3-j)*16 +: 16] = 16'(4*j + k + off);
   endfunction

   task automatic load8(input int off, input bit flat, input bit gaps,
                        output int acc);
      acc = 0;
      for (int r = 0; r < 8; r++) begin
         if (gaps && r > 0) begin
            in_valid = 1'b0;
            if (in_valid && in_ready) acc++;
            tick();
         end
         in_data  = row_x(r, off, flat);
         in_valid = 1'b1;
         if (in_valid && in_ready) acc++;
         tick();
      end
      in_valid = 1'b0;
      chk("latency_out_valid", 128'(out_valid), 128'(1));
      chk("drain_in_ready", 128'(in_ready), 128'(0));
   endtask

   task automatic drain8(input string tag, input int off, input bit flat,
                         input int stall_row);
      for (int k = 0; k < 8; k++) begin
         out_ready = 1'b1;
         if (k == stall_row) begin
            out_ready = 1'b0;
            for (int s = 0; s < 3; s++) begin
               chk({tag, "_stall_data"}, out_data, row_y(k, off, flat));
               chk({tag, "_stall_last"}, 128'(out_last), 128'(0));
               chk({tag, "_stall_valid"}, 128'(out_valid), 128'(1));
               chk({tag, "_stall_in_ready"}, 128'(in_ready), 128'(0));
               tick();
            end
            out_ready = 1'b1;
         end
         chk({tag, "_valid"}, 128'(out_valid), 128'(1));
         chk({tag, "_row"}, out_data, row_y(k, off, flat));
         chk({tag, "_last"}, 128'(out_last), 128'(k == 7));
         if (k == 7) in_valid = 1'b0;
         tick();
      end
      out_ready = 1'b0;
      chk({tag, "_done_in_ready"}, 128'(in_ready), 128'(1));
      chk({tag, "_done_out_valid"}, 128'(out_valid), 128'(0));
      chk({tag, "_done_busy"}, 128'(busy), 128'(0));
   endtask

   initial begin
      int acc, ii, oi;
      logic a;

      reset = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      chk("rst_in_ready", 128'(in_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_out_last", 128'(out_last), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst4_in_ready", 128'(in4_ready), 128'(1));

      // transpose
      load8(0, 1'b0, 1'b0, acc);
      chk("t1_accepts", 128'(acc), 128'(8));
      drain8("t1", 0, 1'b0, -1);

      // backpressure with in_valid held high and junk data during drain
      load8(1, 1'b0, 1'b0, acc);
      in_valid = 1'b1;
      in_data  = '1;
      drain8("t2", 1, 1'b0, 2);

      // narrowing
      gain = 4;
      load8(0, 1'b1, 1'b0, acc);
      drain8("t3", 0, 1'b1, -1);
      gain = 1;

      // reset mid-load
      for (int r = 0; r < 3; r++) begin
         in_data  = row_x(r, 40, 1'b0);
         in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      chk("t4_busy_mid", 128'(busy), 128'(1));
      reset = 1'b0;
      tick();
      reset = 1'b1;
      chk("t4_in_ready", 128'(in_ready), 128'(1));
      chk("t4_busy", 128'(busy), 128'(0));
      chk("t4_out_valid", 128'(out_valid), 128'(0));
      load8(2, 1'b0, 1'b0, acc);
      drain8("t4", 2, 1'b0, -1);

      // input gaps
      load8(0, 1'b0, 1'b1, acc);
      chk("t5_accepts", 128'(acc), 128'(8));
      drain8("t5", 0, 1'b0, -1);

      // N=4 back-to-back blocks
      ii = 0;
      oi = 0;
      out4_ready = 1'b1;
      for (int t = 0; t < 16; t++) begin
         in4_valid = (ii < 8);
         in4_data  = row4_x(ii % 4, 16 * (ii / 4));
         if (t == 4) chk("t6_latency", 128'(out4_valid), 128'(1));
         if (t == 8) begin
            chk("t6_b_start", 128'(ii), 128'(4));
            chk("t6_b_ready", 128'(in4_ready), 128'(1));
         end
         if (out4_valid) begin
            chk("t6_row", 128'(out4_data), 128'(row4_y(oi % 4, 16 * (oi / 4))));
            chk("t6_last", 128'(out4_last), 128'(oi % 4 == 3));
            oi++;
         end
         a = in4_valid && in4_ready;
         tick();
         if (a) ii++;
      end
      in4_valid = 1'b0;
      out4_ready = 1'b0;
      chk("t6_inputs", 128'(ii), 128'(8));
      chk("t6_outputs", 128'(oi), 128'(8));
      chk("t6_idle", 128'(busy4), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
